decompressor_input_sequencer: RTL and testbench

DECOMPRESSOR_INPUT_SEQUENCER -- requirements
Module: decompressor_input_sequencer

---
 rtl/decompressor_input_sequencer.sv | 160 ++++++++++++++++
 tb/tb_decompressor_input_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decompressor_input_sequencer.sv
// Feeds a decompressor from a control-byte stream and a payload byte stream,
// issuing one literal or copy item at a time under dec_busy flow control.
module decompressor_input_sequencer #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] item_count,
    input  logic [7:0]             cw_byte,
    input  logic                   cw_valid,
    output logic                   cw_ready,
    input  logic [7:0]             data_byte,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [15:0]            dec_data_in,
    output logic                   dec_control_word_in,
    output logic                   dec_data_in_valid,
    input  logic                   dec_busy,
    output logic                   seq_busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CW,
        ST_LOAD_B0,
        ST_LOAD_B1,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] idx_inc;
    logic [7:0]             cw_q, cw_d;
    logic [7:0]             b0_q, b0_d;
    logic [7:0]             b1_q, b1_d;
    logic [15:0]            out_data_q, out_data_d;
    logic                   out_ctrl_q, out_ctrl_d;
    logic                   cur_bit;

    // Control bits are consumed MSB-first, one per item.
    assign cur_bit = cw_q[3'd7 - idx_q[2:0]];
    // idx_q never exceeds count_q-1, so the increment cannot wrap.
    assign idx_inc = idx_q + COUNT_WIDTH'(1);

    assign seq_busy = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            cw_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            out_data_q <= '0;
            out_ctrl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            cw_q       <= cw_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        count_d             = count_q;
        idx_d               = idx_q;
        cw_d                = cw_q;
        b0_d                = b0_q;
        b1_d                = b1_q;
        out_data_d          = out_data_q;
        out_ctrl_d          = out_ctrl_q;
        cw_ready            = 1'b0;
        data_ready          = 1'b0;
        dec_data_in_valid   = 1'b0;
        dec_data_in         = out_data_q;
        dec_control_word_in = out_ctrl_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (item_count != '0) begin
                        count_d = item_count;
                        idx_d   = '0;
                        state_d = ST_LOAD_CW;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD_CW: begin
                cw_ready = 1'b1;
                if (cw_valid) begin
                    cw_d    = cw_byte;
                    state_d = ST_LOAD_B0;
                end
            end
            ST_LOAD_B0: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    b0_d    = data_byte;
                    state_d = cur_bit ? ST_LOAD_B1 : ST_ISSUE;
                end
            end
            ST_LOAD_B1: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    b1_d    = data_byte;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Outputs pass the new item through in the issue cycle and
                // hold it afterwards from the registered copy.
                if (!dec_busy) begin
                    out_data_d          = cur_bit ? {b0_q, b1_q} : {8'h00, b0_q};
                    out_ctrl_d          = cur_bit;
                    dec_data_in_valid   = 1'b1;
                    dec_data_in         = out_data_d;
                    dec_control_word_in = out_ctrl_d;
                    state_d             = ST_GUARD;
                end
            end
            ST_GUARD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!dec_busy) begin
                    idx_d = idx_inc;
                    if (idx_inc == count_q) begin
                        state_d = ST_DONE;
                    end else if (idx_inc[2:0] == 3'd0) begin
                        state_d = ST_LOAD_CW;
                    end else begin
                        state_d = ST_LOAD_B0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decompressor_input_sequencer.sv
// Randomized bench: stream producers and a decompressor busy model drive the
// sequencer; issued items are compared with a queue-based reference model.
module tb_decompressor_input_sequencer;

    localparam int unsigned CW = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic [CW-1:0] item_count;
    logic [7:0]    cw_byte;
    logic          cw_valid;
    logic          cw_ready;
    logic [7:0]    data_byte;
    logic          data_valid;
    logic          data_ready;
    logic [15:0]   dec_data_in;
    logic          dec_control_word_in;
    logic          dec_data_in_valid;
    logic          dec_busy;
    logic          seq_busy;
    logic          done;

    decompressor_input_sequencer #(.COUNT_WIDTH(CW)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .item_count          (item_count),
        .cw_byte             (cw_byte),
        .cw_valid            (cw_valid),
        .cw_ready            (cw_ready),
        .data_byte           (data_byte),
        .data_valid          (data_valid),
        .data_ready          (data_ready),
        .dec_data_in         (dec_data_in),
        .dec_control_word_in (dec_control_word_in),
        .dec_data_in_valid   (dec_data_in_valid),
        .dec_busy            (dec_busy),
        .seq_busy            (seq_busy),
        .done                (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [21:0] outs;
    assign outs = {cw_ready, data_ready, dec_data_in_valid, dec_control_word_in,
                   dec_data_in, seq_busy, done};

    int unsigned n_pass;
    int unsigned n_total;

    logic [7:0]  cw_src[$];
    logic [7:0]  dat_src[$];
    logic [16:0] exp_items[$];
    logic [16:0] got_items[$];
    logic [16:0] last_issued;

    int cw_ptr, dat_ptr, dones, overlap, hold_viol, busy_cnt;
    int first_valid_cyc, done_cyc;
    int exp_cw, exp_dat, exp_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic gen_random(input int count);
        cw_src.delete();
        dat_src.delete();
        for (int i = 0; i < (count + 7) / 8 + 2; i++) cw_src.push_back(8'($urandom));
        for (int i = 0; i < 2 * count + 2; i++) dat_src.push_back(8'($urandom));
    endtask

    // Reference: item k is a copy when bit (k mod 8), MSB first, of control
    // byte k/8 is set; literals take one payload byte, copies two.
    task automatic build_expected(input int count);
        int p;
        logic [7:0] cb;
        logic       bk;
        exp_items.delete();
        p       = 0;
        exp_lat = 1 + (count + 7) / 8;
        for (int k = 0; k < count; k++) begin
            cb = cw_src[k / 8];
            bk = cb[7 - (k % 8)];
            if (bk) begin
                exp_items.push_back({1'b1, dat_src[p], dat_src[p + 1]});
                p       += 2;
                exp_lat += 5;
            end else begin
                exp_items.push_back({1'b0, 8'h00, dat_src[p]});
                p       += 1;
                exp_lat += 4;
            end
        end
        exp_cw  = (count + 7) / 8;
        exp_dat = p;
    endtask

    task automatic job_clear();
        cw_ptr          = 0;
        dat_ptr         = 0;
        dones           = 0;
        overlap         = 0;
        hold_viol       = 0;
        busy_cnt        = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
        got_items.delete();
    endtask

    // One clock cycle: drive inputs, observe settled outputs, advance an edge.
    task automatic do_cycle(input int cyc, input bit fast, input int bmode,
                            input bit start_now, input logic [CW-1:0] cnt_in);
        int idx;
        start      = start_now;
        item_count = cnt_in;
        cw_valid   = (cw_ptr < cw_src.size()) && (fast || $urandom_range(0, 2) != 0);
        cw_byte    = cw_valid ? cw_src[cw_ptr] : 8'($urandom);
        data_valid = (dat_ptr < dat_src.size()) && (fast || $urandom_range(0, 2) != 0);
        data_byte  = data_valid ? dat_src[dat_ptr] : 8'($urandom);
        case (bmode)
            1:       dec_busy = ($urandom_range(0, 2) == 0);
            2:       dec_busy = (busy_cnt > 0);
            3:       dec_busy = (cyc <= 12);
            default: dec_busy = 1'b0;
        endcase
        if (busy_cnt > 0) busy_cnt--;
        #1;
        if (cw_ready && cw_valid) cw_ptr++;
        if (data_ready && data_valid) dat_ptr++;
        if (cw_ready && data_ready) overlap++;
        if (dec_data_in_valid) begin
            idx = got_items.size();
            got_items.push_back({dec_control_word_in, dec_data_in});
            last_issued = (idx < exp_items.size()) ? exp_items[idx]
                                                   : {dec_control_word_in, dec_data_in};
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bmode == 2) busy_cnt = 2;
        end else if ({dec_control_word_in, dec_data_in} !== last_issued) begin
            hold_viol++;
        end
        if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_job(input string tag, input int count, input bit fast,
                           input int bmode, input int restart_cyc);
        int cyc;
        job_clear();
        build_expected(count);
        do_cycle(0, fast, bmode, 1'b1, CW'(count));
        cyc = 1;
        while (cyc < 3000 && done_cyc < 0) begin
            do_cycle(cyc, fast, bmode, cyc == restart_cyc, CW'($urandom));
            cyc++;
        end
        repeat (4) begin
            do_cycle(cyc, fast, bmode, 1'b0, '0);
            cyc++;
        end
        check({tag, "_finished"}, 32'(done_cyc >= 0), 1);
        check({tag, "_items"}, got_items.size(), exp_items.size());
        for (int i = 0; i < got_items.size() && i < exp_items.size(); i++)
            check({tag, "_item"}, got_items[i], exp_items[i]);
        check({tag, "_cw_xfers"}, cw_ptr, exp_cw);
        check({tag, "_data_xfers"}, dat_ptr, exp_dat);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_ready_overlap"}, overlap, 0);
        check({tag, "_hold"}, hold_viol, 0);
        check({tag, "_idle_after"}, seq_busy, 0);
        if (fast && bmode == 0) check({tag, "_latency"}, done_cyc, exp_lat);
    endtask

    initial begin
        int cyc;
        int cnt;
        n_pass      = 0;
        n_total     = 0;
        last_issued = '0;
        reset       = 1'b1;
        start       = 1'b0;
        item_count  = '0;
        cw_byte     = '0;
        cw_valid    = 1'b0;
        data_byte   = '0;
        data_valid  = 1'b0;
        dec_busy    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", outs, 0);
        reset = 1'b0;

        gen_random(0);
        run_job("zero_count", 0, 1'b1, 0, -1);

        cw_src  = '{8'h40, 8'h5a, 8'ha5};
        dat_src = '{8'h41, 8'h12, 8'h34, 8'h42, 8'h99, 8'h77};
        run_job("three_items", 3, 1'b1, 2, -1);

        gen_random(9);
        cw_src[0] = 8'h00;
        cw_src[1] = 8'h80;
        run_job("two_cw_bytes", 9, 1'b1, 0, -1);

        gen_random(1);
        cw_src[0] = 8'h00;
        run_job("busy_hold", 1, 1'b1, 3, -1);
        check("busy_release_cycle", first_valid_cyc, 13);

        gen_random(15);
        run_job("max_count", 15, 1'b1, 0, -1);

        for (int i = 0; i < 12; i++) begin
            cnt = $urandom_range(1, 15);
            gen_random(cnt);
            run_job("random", cnt, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                    (i % 2 == 1) ? $urandom_range(3, 25) : -1);
        end

        // Reset while waiting on the decompressor after the second of five items.
        gen_random(5);
        job_clear();
        build_expected(5);
        do_cycle(0, 1'b1, 2, 1'b1, CW'(5));
        cyc = 1;
        while (got_items.size() < 2 && cyc < 500) begin
            do_cycle(cyc, 1'b1, 2, 1'b0, '0);
            cyc++;
        end
        check("reset_reach_item2", got_items.size(), 2);
        do_cycle(cyc, 1'b1, 2, 1'b0, '0);
        reset = 1'b1;
        do_cycle(cyc + 1, 1'b1, 2, 1'b0, '0);
        check("reset_mid_outputs", outs, 0);
        reset       = 1'b0;
        last_issued = '0;
        dones       = 0;
        cw_ptr      = 0;
        dat_ptr     = 0;
        for (int i = 0; i < 6; i++) do_cycle(cyc + 2 + i, 1'b1, 0, 1'b0, '0);
        check("reset_no_done", dones, 0);
        check("reset_no_xfers", cw_ptr + dat_ptr, 0);

        gen_random(1);
        run_job("after_reset", 1, 1'b0, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
